// File: rtl/merge_4x2_if.sv
// merge_4x2_if: bundles the handshake and data signals of merge_4x2.
//   slave  modport: the merge block's view (captures A/B, drives the output stream)
//   master modport: the environment's view (presents A/B, consumes the stream)
// Signals:
//   a_valid/a_ready, a0..a3 : group A capture handshake + ascending words
//   b_valid/b_ready, b0..b3 : group B capture handshake + ascending words
//   out_valid/out_ready     : merged stream handshake
//   out_data/out_src/out_last : merged word, origin (0=A,1=B), 8th-word flag
//   busy                    : a group is held or a merge is in progress
interface merge_4x2_if #(
  parameter int W = 8
);
  logic         a_valid;
  logic         a_ready;
  logic [W-1:0] a0, a1, a2, a3;
  logic         b_valid;
  logic         b_ready;
  logic [W-1:0] b0, b1, b2, b3;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_src;
  logic         out_last;
  logic         busy;

  modport slave (
    input  a_valid, a0, a1, a2, a3,
    input  b_valid, b0, b1, b2, b3,
    input  out_ready,
    output a_ready, b_ready,
    output out_valid, out_data, out_src, out_last, busy
  );

  modport master (
    output a_valid, a0, a1, a2, a3,
    output b_valid, b0, b1, b2, b3,
    output out_ready,
    input  a_ready, b_ready,
    input  out_valid, out_data, out_src, out_last, busy
  );
endinterface

// File: rtl/merge_4x2.sv
// merge_4x2: captures two ascending groups of four words (A and B) and emits
// the eight words one per handshake as a single ascending stream.
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   bus         merge_4x2_if.slave (capture handshakes, output stream, busy)
//   o_dbg_state current FSM state (0 = LOAD, 1 = MERGE)
//   o_dbg_ia    number of A words already emitted (0..4)
//   o_dbg_ib    number of B words already emitted (0..4)
//
// Handshake rule (all three channels): a transfer happens on a rising edge
// where valid and ready are both high. Valid-side data need only be stable in
// that cycle. Ready and all output-stream signals come from registers only,
// so no input reaches an output without passing through a flop.
module merge_4x2 #(
  parameter int W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  merge_4x2_if.slave  bus,
  output logic        o_dbg_state,
  output logic [2:0]  o_dbg_ia,
  output logic [2:0]  o_dbg_ib
);

  localparam logic [0:0] ST_LOAD  = 1'b0;
  localparam logic [0:0] ST_MERGE = 1'b1;

  logic [0:0]   r_state;
  logic         r_a_held;
  logic         r_b_held;
  logic [2:0]   r_ia;
  logic [2:0]   r_ib;
  logic [W-1:0] r_a [4];
  logic [W-1:0] r_b [4];

  logic         w_in_load;
  logic         w_in_merge;
  logic         w_a_ready;
  logic         w_b_ready;
  logic         w_a_fire;
  logic         w_b_fire;
  logic         w_load_done;
  logic [W-1:0] w_a_word;
  logic [W-1:0] w_b_word;
  logic         w_sel_b;
  logic [W-1:0] w_sel_word;
  logic         w_last;
  logic         w_out_fire;

  assign w_in_load  = (r_state == ST_LOAD);
  assign w_in_merge = (r_state == ST_MERGE);

  assign w_a_ready = w_in_load & ~r_a_held;
  assign w_b_ready = w_in_load & ~r_b_held;
  assign w_a_fire  = bus.a_valid & w_a_ready;
  assign w_b_fire  = bus.b_valid & w_b_ready;

  // Both groups become present either now or earlier; covers either arrival
  // order as well as simultaneous capture.
  assign w_load_done = w_in_load & (r_a_held | w_a_fire) & (r_b_held | w_b_fire);

  // Index 4 means the group is exhausted; the low two bits then alias word 0,
  // which is harmless because the selection below ignores an exhausted side.
  assign w_a_word = r_a[r_ia[1:0]];
  assign w_b_word = r_b[r_ib[1:0]];

  always_comb begin
    w_sel_b = 1'b0;
    if (r_ia == 3'd4) begin
      w_sel_b = 1'b1;
    end else if (r_ib == 3'd4) begin
      w_sel_b = 1'b0;
    end else begin
      // Strict compare so equal words go to A, keeping the merge stable.
      w_sel_b = (w_a_word > w_b_word);
    end
  end

  assign w_sel_word = w_sel_b ? w_b_word : w_a_word;
  assign w_last     = (({1'b0, r_ia} + {1'b0, r_ib}) == 4'd7);
  assign w_out_fire = w_in_merge & bus.out_ready;

  // Output stream: zeroed while loading so nothing stale leaks downstream.
  assign bus.a_ready   = w_a_ready;
  assign bus.b_ready   = w_b_ready;
  assign bus.out_valid = w_in_merge;
  assign bus.out_data  = w_in_merge ? w_sel_word : '0;
  assign bus.out_src   = w_in_merge & w_sel_b;
  assign bus.out_last  = w_in_merge & w_last;
  assign bus.busy      = w_in_merge | r_a_held | r_b_held;

  assign o_dbg_state = r_state;
  assign o_dbg_ia    = r_ia;
  assign o_dbg_ib    = r_ib;

  // Control: FSM, held flags and read indices.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_LOAD;
      r_a_held <= 1'b0;
      r_b_held <= 1'b0;
      r_ia     <= 3'd0;
      r_ib     <= 3'd0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_a_fire) r_a_held <= 1'b1;
          if (w_b_fire) r_b_held <= 1'b1;
          if (w_load_done) begin
            r_state <= ST_MERGE;
            r_ia    <= 3'd0;
            r_ib    <= 3'd0;
          end
        end
        ST_MERGE: begin
          if (w_out_fire) begin
            if (w_sel_b) r_ib <= r_ib + 3'd1;
            else         r_ia <= r_ia + 3'd1;
            if (w_last) begin
              r_state  <= ST_LOAD;
              r_a_held <= 1'b0;
              r_b_held <= 1'b0;
            end
          end
        end
        default: r_state <= ST_LOAD;
      endcase
    end
  end

  // Group storage: written only on the capture handshake of each group.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        r_a[i] <= '0;
        r_b[i] <= '0;
      end
    end else begin
      if (w_a_fire) begin
        r_a[0] <= bus.a0;
        r_a[1] <= bus.a1;
        r_a[2] <= bus.a2;
        r_a[3] <= bus.a3;
      end
      if (w_b_fire) begin
        r_b[0] <= bus.b0;
        r_b[1] <= bus.b1;
        r_b[2] <= bus.b2;
        r_b[3] <= bus.b3;
      end
    end
  end

endmodule

// File: tb/tb_merge_4x2.sv
// tb_merge_4x2: directed bench for merge_4x2. A table of {A, B, expected
// stream} records drives the plain merges; hand-written sequences cover
// staggered loading, exhaustion, backpressure, mid-merge reset and
// back-to-back merges. Expected words flow through exp_q as {last, src, data}.
module tb_merge_4x2;
  localparam int W = 8;

  typedef struct {
    logic [W-1:0] a [4];
    logic [W-1:0] b [4];
    logic [W-1:0] d [8];
    logic         s [8];
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       dbg_state;
  logic [2:0] dbg_ia;
  logic [2:0] dbg_ib;

  merge_4x2_if #(.W(W)) bus ();

  merge_4x2 #(.W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state),
    .o_dbg_ia    (dbg_ia),
    .o_dbg_ib    (dbg_ib)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int            n_checks = 0;
  int            n_errors = 0;
  logic [W+1:0]  exp_q [$];
  vec_t          vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_vec(input int k, input int first, input int count);
    for (int i = first; i < first + count; i++)
      exp_q.push_back({(i == 7), vecs[k].s[i], vecs[k].d[i]});
  endtask

  // ---------------- driver tasks ----------------
  // All drive tasks start and end #1 after a rising edge.
  task automatic load_vec(input int k);
    bus.a_valid = 1'b1;
    bus.a0 = vecs[k].a[0]; bus.a1 = vecs[k].a[1];
    bus.a2 = vecs[k].a[2]; bus.a3 = vecs[k].a[3];
    bus.b_valid = 1'b1;
    bus.b0 = vecs[k].b[0]; bus.b1 = vecs[k].b[1];
    bus.b2 = vecs[k].b[2]; bus.b3 = vecs[k].b[3];
    @(posedge clk); #1;
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    chk("cap_out_valid", bus.out_valid, 1);
    chk("cap_a_ready", bus.a_ready, 0);
    chk("cap_b_ready", bus.b_ready, 0);
    chk("cap_busy", bus.busy, 1);
  endtask

  // Consume until exp_q is empty. rdy_pat bit n is out_ready in cycle n.
  task automatic drain(input logic [31:0] rdy_pat);
    int           cyc;
    logic         prev_stall;
    logic [W-1:0] prev_d;
    logic [W+1:0] e;
    cyc = 0;
    prev_stall = 1'b0;
    prev_d = '0;
    bus.out_ready = rdy_pat[0];
    while (exp_q.size() > 0 && cyc < 64) begin
      @(negedge clk);
      chk("merge_out_valid", bus.out_valid, 1);
      if (prev_stall) chk("stall_hold_data", bus.out_data, prev_d);
      if (bus.out_valid && bus.out_ready) begin
        e = exp_q.pop_front();
        chk("out_data", bus.out_data, e[W-1:0]);
        chk("out_src", bus.out_src, e[W]);
        chk("out_last", bus.out_last, e[W+1]);
        prev_stall = 1'b0;
      end else begin
        prev_stall = bus.out_valid;
        prev_d = bus.out_data;
      end
      @(posedge clk); #1;
      cyc++;
      bus.out_ready = (cyc < 32) ? rdy_pat[cyc] : 1'b1;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout remaining=%0d expected=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_idle();
    chk("idle_out_valid", bus.out_valid, 0);
    chk("idle_a_ready", bus.a_ready, 1);
    chk("idle_b_ready", bus.b_ready, 1);
    chk("idle_busy", bus.busy, 0);
    chk("idle_out_data", bus.out_data, 0);
    chk("idle_state", dbg_state, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    // 0: test-plan merge; 1: exhaustion; 2: reversed groups; 3: ties at 255
    vecs[0].a = '{8'd2, 8'd3, 8'd5, 8'd9};       vecs[0].b = '{8'd1, 8'd4, 8'd5, 8'd8};
    vecs[0].d = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd5, 8'd8, 8'd9};
    vecs[0].s = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[1].a = '{8'd0, 8'd1, 8'd2, 8'd3};       vecs[1].b = '{8'd10, 8'd20, 8'd30, 8'd40};
    vecs[1].d = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd10, 8'd20, 8'd30, 8'd40};
    vecs[1].s = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[2].a = '{8'd5, 8'd6, 8'd7, 8'd8};       vecs[2].b = '{8'd1, 8'd2, 8'd3, 8'd4};
    vecs[2].d = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    vecs[2].s = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3].a = '{8'd255, 8'd255, 8'd255, 8'd255}; vecs[3].b = '{8'd0, 8'd128, 8'd255, 8'd255};
    vecs[3].d = '{8'd0, 8'd128, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
    vecs[3].s = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    // 4: staggered load; 5: all-equal back-to-back; 6: decoy A data
    vecs[4].a = '{8'd9, 8'd9, 8'd9, 8'd9};       vecs[4].b = '{8'd0, 8'd0, 8'd0, 8'd255};
    vecs[4].d = '{8'd0, 8'd0, 8'd0, 8'd9, 8'd9, 8'd9, 8'd9, 8'd255};
    vecs[4].s = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5].a = '{8'd1, 8'd1, 8'd1, 8'd1};       vecs[5].b = '{8'd1, 8'd1, 8'd1, 8'd1};
    vecs[5].d = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
    vecs[5].s = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[6].a = '{8'd7, 8'd7, 8'd7, 8'd7};       vecs[6].b = '{8'd7, 8'd7, 8'd7, 8'd7};
    vecs[6].d = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    vecs[6].s = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0;
    bus.a_valid = 1'b0; bus.b_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a0 = '0; bus.a1 = '0; bus.a2 = '0; bus.a3 = '0;
    bus.b0 = '0; bus.b1 = '0; bus.b2 = '0; bus.b3 = '0;
    repeat (2) @(posedge clk);
    #1;
    check_idle();
    chk("rst_out_src", bus.out_src, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_ia", dbg_ia, 0);
    chk("rst_ib", dbg_ib, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven merges with out_ready held high.
    for (int k = 0; k < 4; k++) begin
      load_vec(k);
      push_vec(k, 0, 8);
      drain(32'hFFFF_FFFF);
      check_idle();
    end

    // Staggered: A first, further A valids (decoy data) ignored, B later.
    bus.a_valid = 1'b1;
    bus.a0 = vecs[4].a[0]; bus.a1 = vecs[4].a[1]; bus.a2 = vecs[4].a[2]; bus.a3 = vecs[4].a[3];
    @(posedge clk); #1;
    bus.a0 = vecs[6].a[0]; bus.a1 = vecs[6].a[1]; bus.a2 = vecs[6].a[2]; bus.a3 = vecs[6].a[3];
    chk("stag_a_ready", bus.a_ready, 0);
    chk("stag_b_ready", bus.b_ready, 1);
    chk("stag_busy", bus.busy, 1);
    for (int i = 0; i < 3; i++) begin
      chk("stag_out_valid", bus.out_valid, 0);
      @(posedge clk); #1;
    end
    bus.b_valid = 1'b1;
    bus.b0 = vecs[4].b[0]; bus.b1 = vecs[4].b[1]; bus.b2 = vecs[4].b[2]; bus.b3 = vecs[4].b[3];
    chk("stag_pre_b_out_valid", bus.out_valid, 0);
    @(posedge clk); #1;
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    chk("stag_post_b_out_valid", bus.out_valid, 1);
    push_vec(4, 0, 8);
    drain(32'hFFFF_FFFF);
    check_idle();

    // Exhaustion: after the four A words ia sits at 4 and B drains.
    load_vec(1);
    push_vec(1, 0, 4);
    drain(32'hFFFF_FFFF);
    chk("exh_ia", dbg_ia, 4);
    chk("exh_ib", dbg_ib, 0);
    push_vec(1, 4, 4);
    drain(32'hFFFF_FFFF);
    check_idle();

    // Backpressure: out_ready 1,0,0,1,0,1,1,1,1,1.
    load_vec(0);
    push_vec(0, 0, 8);
    drain(32'hFFFF_FFE9);
    check_idle();

    // Reset after three handshakes, then reload.
    load_vec(0);
    push_vec(0, 0, 3);
    drain(32'hFFFF_FFFF);
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check_idle();
    @(posedge clk); #1;
    rst_n = 1'b1;
    load_vec(2);
    push_vec(2, 0, 8);
    drain(32'hFFFF_FFFF);
    check_idle();

    // Back-to-back: next groups wait with valids high during a merge.
    load_vec(0);
    bus.a_valid = 1'b1;
    bus.a0 = vecs[5].a[0]; bus.a1 = vecs[5].a[1]; bus.a2 = vecs[5].a[2]; bus.a3 = vecs[5].a[3];
    bus.b_valid = 1'b1;
    bus.b0 = vecs[5].b[0]; bus.b1 = vecs[5].b[1]; bus.b2 = vecs[5].b[2]; bus.b3 = vecs[5].b[3];
    push_vec(0, 0, 8);
    drain(32'hFFFF_FFFF);
    chk("b2b_a_ready", bus.a_ready, 1);
    chk("b2b_b_ready", bus.b_ready, 1);
    chk("b2b_gap_out_valid", bus.out_valid, 0);
    @(posedge clk); #1;
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    chk("b2b_out_valid", bus.out_valid, 1);
    push_vec(5, 0, 8);
    drain(32'hFFFF_FFFF);
    check_idle();

    // ---------------- final report ----------------
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
